// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - shared mode definitions for the JK flip-flop bank
package jk_pkg;

  typedef enum logic [1:0] {
    MODE_JK    = 2'b00,
    MODE_COUNT = 2'b01,
    MODE_SHIFT = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - next-state logic for one JK channel with reset, clear, preset and enable
module jk_cell (
  input  logic q,
  input  logic j,
  input  logic k,
  input  logic pre_n,
  input  logic clr_n,
  input  logic rst,
  input  logic ce,
  output logic q_next
);

  // Priority: reset, clear, preset, enable, then the JK function.
  always_comb begin
    q_next = q;
    if (rst) begin
      q_next = 1'b0;
    end else if (!clr_n) begin
      q_next = 1'b0;
    end else if (!pre_n) begin
      q_next = 1'b1;
    end else if (ce) begin
      case ({j, k})
        2'b01:   q_next = 1'b0;
        2'b10:   q_next = 1'b1;
        2'b11:   q_next = ~q;
        default: q_next = q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank.sv
// rtl/jk_bank.sv - WIDTH-channel JK bank with JK, up/down count, shift and hold modes
module jk_bank
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic [1:0]       MODE,
  input  logic             DIR,
  input  logic             SI,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] PRE_N,
  input  logic [WIDTH-1:0] CLR_N,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             SO,
  output logic             TC
);

  mode_e            mode;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] j_eff;
  logic [WIDTH-1:0] k_eff;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] shift_d;
  logic             all_ones;
  logic             all_zeros;

  assign mode = mode_e'(MODE);

  // Counter toggles come from the pre-edge Q: bit i flips when every lower bit
  // is 1 (up) or 0 (down); bit 0 always flips.
  always_comb begin
    logic acc_up;
    logic acc_dn;
    toggle = '0;
    acc_up = 1'b1;
    acc_dn = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      toggle[i] = DIR ? acc_up : acc_dn;
      acc_up    = acc_up & q_r[i];
      acc_dn    = acc_dn & ~q_r[i];
    end
  end

  assign shift_d = {q_r[WIDTH-2:0], SI};

  always_comb begin
    j_eff = '0;
    k_eff = '0;
    case (mode)
      MODE_JK: begin
        j_eff = J;
        k_eff = K;
      end
      MODE_COUNT: begin
        j_eff = toggle;
        k_eff = toggle;
      end
      MODE_SHIFT: begin
        j_eff = shift_d;
        k_eff = ~shift_d;
      end
      default: begin
        j_eff = '0;
        k_eff = '0;
      end
    endcase
  end

  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_cell
    jk_cell u_cell (
      .q      (q_r[g]),
      .j      (j_eff[g]),
      .k      (k_eff[g]),
      .pre_n  (PRE_N[g]),
      .clr_n  (CLR_N[g]),
      .rst    (RST),
      .ce     (CE),
      .q_next (q_next[g])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_r <= '0;
    end else begin
      q_r <= q_next;
    end
  end

  assign all_ones  = &q_r;
  assign all_zeros = ~|q_r;

  // Combinational so a cascaded stage sees TC in the same cycle the count is terminal.
  assign TC = CE & (mode == MODE_COUNT) & (DIR ? all_ones : all_zeros);

  assign Q  = q_r;
  assign QN = ~q_r;
  assign SO = q_r[WIDTH-1];

endmodule
